// File: rtl/mem_latency_responder.sv
// -----------------------------------------------------------------------------
// mem_latency_responder
//
// Memory-side responder that models slow main memory behind a valid/ready
// request interface. It accepts one read or write per transaction and answers
// after a fixed number of cycles. A read returns either one word or a 4-word
// line fill. The line fill is delivered critical word first and wraps inside
// the 8-byte aligned line. A write is acknowledged with a single beat, and the
// word is committed at the edge that ends that beat.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_valid_i   initiator presents a request
//   req_ready_o   responder idle and able to accept a request
//   req_write_i   1 = write, 0 = read
//   req_burst_i   1 = 4-word wrapped line read (ignored for writes)
//   req_addr_i    byte address; bit 0 and bits above DEPTH_LOG2 are ignored
//   req_wdata_i   write data
//   resp_valid_o  response beat valid (no backpressure)
//   resp_data_o   read data for the beat; 0 on write acknowledge and when idle
//   resp_last_o   final beat of the transaction
// -----------------------------------------------------------------------------
module mem_latency_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4,   // 1..15 cycles from accept to first beat
  parameter int BURST_LEN  = 4    // line fill length; only 4 is supported
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic              req_burst_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_last_o
);

  localparam int               DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]       LAT_INIT  = 4'(LATENCY - 1);
  localparam logic [1:0]       LAST_BEAT = 2'(BURST_LEN - 1);

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT
  } state_t;

  // Word storage
  logic [DATA_W-1:0] mem [DEPTH];

  // Transaction state
  state_t            state_q;
  logic [3:0]        lat_q;
  logic [1:0]        beat_q;
  idx_t              idx_q;
  logic              write_q;
  logic              burst_q;
  logic [DATA_W-1:0] wdata_q;

  // Registered outputs
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_last_q;
  logic [DATA_W-1:0] resp_data_q;

  // Read port: the word that will be presented on the next beat
  idx_t              req_idx;
  idx_t              rd_idx_d;
  logic [DATA_W-1:0] rd_data;
  logic              accept;
  logic              req_is_burst;
  logic              mem_we;

  // Bit 0 and the aliased upper address bits take no part in the design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr_i[ADDR_W-1:DEPTH_LOG2+1], req_addr_i[0]};

  assign req_idx      = req_addr_i[DEPTH_LOG2:1];
  assign accept       = req_valid_i & req_ready_q;
  assign req_is_burst = req_burst_i & ~req_write_i;

  // The last beat of a write is the acknowledge; commit on the edge ending it.
  assign mem_we = (state_q == S_BEAT) & write_q & resp_last_q;

  always_comb begin
    // NOTE: default assignment first so no path leaves rd_idx_d unassigned,
    // which would otherwise infer a latch.
    rd_idx_d = idx_q;
    case (state_q)
      // Only reachable into BEAT directly when LATENCY == 1.
      S_IDLE:  rd_idx_d = req_idx;
      // Next beat of a line fill: keep the line, wrap the word offset.
      S_BEAT:  rd_idx_d = {idx_q[DEPTH_LOG2-1:2], 2'(idx_q[1:0] + beat_q + 2'd1)};
      default: rd_idx_d = idx_q;
    endcase
  end

  assign rd_data = mem[rd_idx_d];

  // NOTE: storage is deliberately left out of reset; only control state is
  // reset, so contents survive rst_n and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lat_q        <= '0;
      beat_q       <= '0;
      idx_q        <= '0;
      write_q      <= 1'b0;
      burst_q      <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            idx_q       <= req_idx;
            write_q     <= req_write_i;
            burst_q     <= req_is_burst;
            wdata_q     <= req_wdata_i;
            beat_q      <= '0;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              // First beat is presented in the cycle right after acceptance.
              state_q      <= S_BEAT;
              resp_valid_q <= 1'b1;
              resp_last_q  <= ~req_is_burst;
              resp_data_q  <= req_write_i ? '0 : rd_data;
            end else begin
              state_q <= S_WAIT;
              lat_q   <= LAT_INIT;
            end
          end
        end

        S_WAIT: begin
          // The beat registers load on the edge where the counter shows 1,
          // so the first beat lands LATENCY-1 edges after acceptance.
          if (lat_q == 4'd1) begin
            state_q      <= S_BEAT;
            lat_q        <= '0;
            resp_valid_q <= 1'b1;
            resp_last_q  <= ~burst_q;
            resp_data_q  <= write_q ? '0 : rd_data;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end

        S_BEAT: begin
          if (resp_last_q) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_data_q  <= '0;
          end else begin
            beat_q      <= beat_q + 2'd1;
            resp_data_q <= rd_data;
            resp_last_q <= (2'(beat_q + 2'd1) == LAST_BEAT);
          end
        end

        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_last_q  <= 1'b0;
          resp_data_q  <= '0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_last_o  = resp_last_q;
  assign resp_data_o  = resp_data_q;

endmodule

// File: tb/tb_mem_latency_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_latency_responder
//
// Two responders share clock and reset: dut0 with LATENCY=4 and dut1 with
// LATENCY=1. When the bench issues a request, it pushes the expected beats
// (data, last flag, and the cycle in which each beat must appear) onto a
// per-DUT queue. A negedge monitor pops and compares every beat the DUTs
// produce. Between beats, the monitor checks that the idle outputs are zero.
// -----------------------------------------------------------------------------
module tb_mem_latency_responder;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic        req_burst  [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [15:0] resp_data  [2];
  logic        resp_last  [2];

  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  int          exp_ready [2];
  beat_t       q0 [$];
  beat_t       q1 [$];
  logic [15:0] model [int];   // key: dut*4096 + word index

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_latency_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12),
                          .LATENCY(4), .BURST_LEN(4)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid[0]),
    .req_ready_o (req_ready[0]),
    .req_write_i (req_write[0]),
    .req_burst_i (req_burst[0]),
    .req_addr_i  (req_addr[0]),
    .req_wdata_i (req_wdata[0]),
    .resp_valid_o(resp_valid[0]),
    .resp_data_o (resp_data[0]),
    .resp_last_o (resp_last[0])
  );

  mem_latency_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12),
                          .LATENCY(1), .BURST_LEN(4)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid[1]),
    .req_ready_o (req_ready[1]),
    .req_write_i (req_write[1]),
    .req_burst_i (req_burst[1]),
    .req_addr_i  (req_addr[1]),
    .req_wdata_i (req_wdata[1]),
    .resp_valid_o(resp_valid[1]),
    .resp_data_o (resp_data[1]),
    .resp_last_o (resp_last[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare one DUT's outputs against the head of its scoreboard queue.
  task automatic mon(input int s);
    beat_t e;
    int    qs;
    qs = (s == 0) ? q0.size() : q1.size();
    if (resp_valid[s] === 1'b1) begin
      check($sformatf("dut%0d_ready_low_in_beat", s), 32'(req_ready[s]), 32'd0);
      if (qs == 0) begin
        check($sformatf("dut%0d_unexpected_beat", s), 32'(resp_valid[s]), 32'd0);
      end else begin
        e = (s == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("dut%0d_beat_data", s), 32'(resp_data[s]), 32'(e.data));
        check($sformatf("dut%0d_beat_last", s), 32'(resp_last[s]), 32'(e.last));
        check($sformatf("dut%0d_beat_cycle", s), cyc, e.cyc);
      end
    end else begin
      check($sformatf("dut%0d_idle_outputs", s), {15'd0, resp_last[s], resp_data[s]}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Drive one request and wait (bounded) for it to be accepted. When commit
  // is set, the expected beats are queued and a write updates the model.
  task automatic issue(input int s, input bit wr, input bit burst,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input bit commit);
    int    lat;
    int    n;
    int    a;
    int    nb;
    int    base;
    int    w;
    beat_t b;
    lat = (s == 0) ? 4 : 1;
    n   = 0;
    @(negedge clk);
    req_valid[s] = 1'b1;
    req_write[s] = wr;
    req_burst[s] = burst;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    while (req_ready[s] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("dut%0d_accept_in_time", s), 32'(n < 100), 32'd1);
    a    = cyc + 1;                   // cycle following the accepting edge
    nb   = (burst && !wr) ? 4 : 1;
    base = (int'(addr) >> 1) & 32'hFFF;
    if (commit) begin
      for (int k = 0; k < nb; k++) begin
        w      = (base & ~3) | ((base + k) & 3);
        b.data = wr ? 16'h0000 : model[s*4096 + w];
        b.last = (k == nb - 1);
        b.cyc  = a + lat - 1 + k;
        if (s == 0) q0.push_back(b);
        else        q1.push_back(b);
      end
      if (wr) model[s*4096 + base] = wdata;
    end
    exp_ready[s] = a + lat + nb - 1;
    @(negedge clk);
    req_valid[s] = 1'b0;
  endtask

  // Wait (bounded) until all queued beats are seen and ready has returned.
  task automatic wait_done(input int s);
    int n;
    n = 0;
    while ((((s == 0) ? q0.size() : q1.size()) != 0 || req_ready[s] !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("dut%0d_done_in_time", s), 32'(n < 100), 32'd1);
    check($sformatf("dut%0d_ready_return_cycle", s), cyc, exp_ready[s]);
  endtask

  initial begin
    logic [15:0] pre [4];
    pre = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_write[s] = 1'b0;
      req_burst[s] = 1'b0;
      req_addr[s]  = '0;
      req_wdata[s] = '0;
    end

    // Reset then idle
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        check($sformatf("dut%0d_reset_ready", s), 32'(req_ready[s]), 32'd1);
        check($sformatf("dut%0d_reset_valid", s), 32'(resp_valid[s]), 32'd0);
      end
    end

    // Write then single read (LATENCY=4)
    issue(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b1);
    wait_done(0);
    issue(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1);
    wait_done(0);

    // Burst wrap order
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 1'b0, 16'(16'h0020 + 2*i), pre[i], 1'b1);
      wait_done(0);
    end
    issue(0, 1'b0, 1'b1, 16'h0024, 16'h0000, 1'b1);
    wait_done(0);

    // Busy rejection: a held read is taken only when ready returns
    issue(0, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1);
    issue(0, 1'b0, 1'b0, 16'h0026, 16'h0000, 1'b1);
    wait_done(0);

    // Reset during the WAIT phase of a write discards it
    issue(0, 1'b1, 1'b0, 16'h0040, 16'h5555, 1'b1);
    wait_done(0);
    issue(0, 1'b1, 1'b0, 16'h0040, 16'hAAAA, 1'b0);
    rst_n = 1'b0;
    #1;
    check("dut0_abort_ready", 32'(req_ready[0]), 32'd1);
    check("dut0_abort_valid", 32'(resp_valid[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(0, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1);
    wait_done(0);

    // LATENCY=1 with address aliasing and bit 0 ignored
    issue(1, 1'b1, 1'b0, 16'h0002, 16'h1234, 1'b1);
    wait_done(1);
    issue(1, 1'b0, 1'b0, 16'h2002, 16'h0000, 1'b1);
    wait_done(1);
    issue(1, 1'b0, 1'b0, 16'h2003, 16'h0000, 1'b1);
    wait_done(1);
    issue(1, 1'b1, 1'b0, 16'h0000, 16'h00A0, 1'b1);
    wait_done(1);
    issue(1, 1'b1, 1'b0, 16'h0004, 16'h00A4, 1'b1);
    wait_done(1);
    issue(1, 1'b1, 1'b0, 16'h0006, 16'h00A6, 1'b1);
    wait_done(1);
    issue(1, 1'b0, 1'b1, 16'h4006, 16'h0000, 1'b1);
    wait_done(1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
